round_share_arbiter: RTL

- Shares one round-half-to-even / saturating rounding stage among N_REQ requesters.
- Each requester offers wide fixed-point samples over a valid/ready handshake.
- Round-robin arbitration picks one request per cycle and pushes it through a 2-stage pipeline.
- Results leave tagged with the source channel id under downstream backpressure.
- Sits between per-channel accumulators/filters and a narrow shared output bus.

---
 rtl/round_share_arbiter_if.sv | 28 ++
 rtl/round_share_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/round_share_arbiter_if.sv
// Bundle of requester-side and output-side handshake signals for round_share_arbiter.
// The arbiter connects through the slave modport; the requesters/downstream side uses master.
interface round_share_arbiter_if #(
  parameter int N_REQ     = 4,
  parameter int WIDTH_IN  = 16,
  parameter int WIDTH_OUT = 8,
  parameter int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
   logic [N_REQ-1:0]          req_valid;
   logic [N_REQ-1:0]          req_ready;
   logic [N_REQ*WIDTH_IN-1:0] req_data;
   logic                      out_valid;
   logic                      out_ready;
   logic [WIDTH_OUT-1:0]      out_data;
   logic [ID_W-1:0]           out_id;
   logic                      out_sat;
   logic                      busy;

   modport slave (
      input  req_valid, req_data, out_ready,
      output req_ready, out_valid, out_data, out_id, out_sat, busy
   );

   modport master (
      output req_valid, req_data, out_ready,
      input  req_ready, out_valid, out_data, out_id, out_sat, busy
   );
endinterface

// File: rtl/round_share_arbiter.sv
// Round-robin arbiter feeding one shared 2-stage round-half-to-even / saturate
// pipeline; results leave tagged with their source channel id.
module round_share_arbiter #(
   parameter int N_REQ     = 4,
   parameter int WIDTH_IN  = 16,
   parameter int WIDTH_OUT = 8,
   parameter bit IS_SIGNED = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   round_share_arbiter_if.slave bus
);
   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int DIFF = WIDTH_IN - WIDTH_OUT;

   // Handshake: a beat moves when valid && ready are both high at a rising
   // edge; valid may not wait on ready, ready never looks at data.
   logic [ID_W-1:0]      ptr;
   logic [ID_W-1:0]      grant;
   logic                 any_valid;
   logic                 adv;
   logic                 transfer;
   logic [WIDTH_IN-1:0]  grant_data;

   logic                 s1_valid;
   logic [WIDTH_IN-1:0]  s1_data;
   logic [ID_W-1:0]      s1_id;

   logic                 s2_valid;
   logic [WIDTH_OUT-1:0] s2_data;
   logic [ID_W-1:0]      s2_id;
   logic                 s2_sat;

   logic [WIDTH_OUT-1:0] trunc;
   logic [DIFF-1:0]      frac;
   logic [DIFF-1:0]      half;
   logic                 up;
   logic [WIDTH_OUT:0]   ext;
   logic [WIDTH_OUT:0]   sum;
   logic                 ovf;
   logic [WIDTH_OUT-1:0] sat_val;
   logic [WIDTH_OUT-1:0] rnd_data;

   // Scan from ptr, wrapping modulo N_REQ; first valid channel wins.
   always_comb begin
      any_valid = 1'b0;
      grant     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         int unsigned idx;
         idx = (int'(ptr) + k) % N_REQ;
         if (!any_valid && bus.req_valid[idx]) begin
            any_valid = 1'b1;
            grant     = ID_W'(idx);
         end
      end
   end

   assign adv        = !s2_valid || bus.out_ready;
   assign transfer   = rst_n && adv && any_valid;
   assign grant_data = bus.req_data[grant*WIDTH_IN +: WIDTH_IN];

   always_comb begin
      bus.req_ready = '0;
      if (transfer) bus.req_ready[grant] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (transfer) begin
         ptr <= (grant == ID_W'(N_REQ - 1)) ? '0 : grant + ID_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_id    <= '0;
      end else if (adv) begin
         s1_valid <= transfer;
         s1_data  <= grant_data;
         s1_id    <= grant;
      end
   end

   // Truncation is floor in both signednesses, so adding 'up' rounds negatives correctly.
   always_comb begin
      trunc   = s1_data[WIDTH_IN-1:DIFF];
      frac    = s1_data[DIFF-1:0];
      half    = '0;
      half[DIFF-1] = 1'b1;
      up      = (frac > half) || ((frac == half) && trunc[0]);
      ext     = IS_SIGNED ? {trunc[WIDTH_OUT-1], trunc} : {1'b0, trunc};
      sum     = ext + {{WIDTH_OUT{1'b0}}, up};
      ovf     = IS_SIGNED ? (sum[WIDTH_OUT] != sum[WIDTH_OUT-1]) : sum[WIDTH_OUT];
      sat_val = '1;
      if (IS_SIGNED) sat_val[WIDTH_OUT-1] = 1'b0;
      rnd_data = ovf ? sat_val : sum[WIDTH_OUT-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_data  <= '0;
         s2_id    <= '0;
         s2_sat   <= 1'b0;
      end else if (adv) begin
         s2_valid <= s1_valid;
         s2_data  <= rnd_data;
         s2_id    <= s1_id;
         s2_sat   <= ovf;
      end
   end

   assign bus.out_valid = s2_valid;
   assign bus.out_data  = s2_data;
   assign bus.out_id    = s2_id;
   assign bus.out_sat   = s2_sat;
   assign bus.busy      = s1_valid || s2_valid;
endmodule
